// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor.
// The operands are cut into WIDTH/SLICE slices. Pipeline stage k resolves slice k and
// passes its carry to stage k+1. Latency is WIDTH/SLICE register stages.
//
// Handshake: an input is taken on a rising edge where in_valid && in_ready. A result
// is consumed on a rising edge where out_valid && out_ready. The whole pipe moves
// together on adv = !out_valid || out_ready, and in_ready equals adv
// (combinational from out_ready). When adv is low, every stage holds its valid bit,
// data and carry.
module pipelined_ripple_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SLICE;

  if (SLICE < 1 || WIDTH % SLICE != 0) begin : g_bad_params
    $error("pipelined_ripple_adder: WIDTH must be a non-zero multiple of SLICE");
  end

  // Per-stage registers. The operand registers hold only the slices that are not yet
  // consumed, and the sum register collects the slices resolved so far.
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q;

  // Stage inputs (the previous stage's registers, or the ports for stage 0) and the
  // next-state values.
  logic             vld_src [STAGES];
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] s_src   [STAGES];
  logic             c_src   [STAGES];
  logic [WIDTH-1:0] a_nxt   [STAGES];
  logic [WIDTH-1:0] b_nxt   [STAGES];
  logic [WIDTH-1:0] s_nxt   [STAGES];
  logic             c_nxt   [STAGES];
  logic             ovf_nxt;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] keep_mask;
  logic             adv;

  assign out_valid = vld_q[STAGES-1];
  assign S         = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Route each stage's inputs. Subtraction uses A + ~B + 1, and in that mode cin is
  // ignored.
  always_comb begin
    vld_src[0] = in_valid;
    a_src[0]   = A;
    b_src[0]   = sub ? ~B : B;
    s_src[0]   = '0;
    c_src[0]   = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      vld_src[k] = vld_q[k-1];
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      s_src[k]   = s_q[k-1];
      c_src[k]   = c_q[k-1];
    end
  end

  // Resolve one slice per stage. The last stage also derives the carry into the MSB
  // for the signed overflow flag.
  always_comb begin
    slice_sum = '0;
    keep_mask = '0;
    ovf_nxt   = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      slice_sum = {1'b0, a_src[k][k*SLICE +: SLICE]}
                + {1'b0, b_src[k][k*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, c_src[k]};
      s_nxt[k]                   = s_src[k];
      s_nxt[k][k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
      c_nxt[k]                   = slice_sum[SLICE];
      keep_mask = {WIDTH{1'b1}} << ((k + 1) * SLICE);
      a_nxt[k]  = a_src[k] & keep_mask;
      b_nxt[k]  = b_src[k] & keep_mask;
    end
    ovf_nxt = (a_src[STAGES-1][WIDTH-1] ^ b_src[STAGES-1][WIDTH-1]
               ^ s_nxt[STAGES-1][WIDTH-1]) ^ c_nxt[STAGES-1];
  end

  // Pipeline registers. Reset clears everything, which discards any in-flight
  // operations. Otherwise all stages advance together on adv.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_src[k];
        a_q[k]   <= a_nxt[k];
        b_q[k]   <= b_nxt[k];
        s_q[k]   <= s_nxt[k];
        c_q[k]   <= c_nxt[k];
      end
      ovf_q <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder. Three configurations run side by side:
// 32/4, 16/8 and 8/1. Each configuration has its own driver, ready generator and
// monitor. The expected results come from a signed/unsigned integer model.
module tb_pipelined_ripple_adder;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   done [3];

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W   = (g == 0) ? 32 : (g == 1) ? 16 : 8;
    localparam int SL  = (g == 0) ? 4  : (g == 1) ? 8  : 1;
    localparam int STG = W / SL;

    logic         reset_n, in_valid, in_ready, cin, sub;
    logic         out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, s;
    logic [W+1:0] exp_q[$];
    int           ready_mode;

    pipelined_ripple_adder #(.WIDTH(W), .SLICE(SL)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .S(s), .cout(cout), .ovf(ovf)
    );

    // Reference: plain integer arithmetic. Signed overflow means the exact signed
    // result falls outside the W-bit range.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic su);
      longint ux, uy, ur, sx, sy, sr, smax, smin;
      logic [W-1:0] r;
      logic co, ov;
      ux   = longint'(x);
      uy   = longint'(y);
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      smax = (longint'(1) << (W - 1)) - 1;
      smin = -(longint'(1) << (W - 1));
      if (su) begin
        ur = ux - uy;
        sr = sx - sy;
        co = (ux >= uy);
      end else begin
        ur = ux + uy + longint'(c);
        sr = sx + sy + longint'(c);
        co = (ur >= (longint'(1) << W));
      end
      r  = ur[W-1:0];
      ov = (sr > smax) || (sr < smin);
      return {ov, co, r};
    endfunction

    // Drive one operation and hold it until accepted. The expected result is pushed
    // on the negedge before the accepting edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic su);
      int n = 0;
      bit acc = 1'b0;
      a = x; b = y; cin = c; sub = su; in_valid = 1'b1;
      while (!acc && n < 300) begin
        @(negedge clk);
        if (in_ready === 1'b1) begin
          acc = 1'b1;
          exp_q.push_back(model(x, y, c, su));
        end
        @(posedge clk); #1;
        n++;
      end
      in_valid = 1'b0;
      check($sformatf("w%0d_accept", W), 64'(acc), 64'd1);
    endtask

    task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("w%0d_drain", W), 64'(exp_q.size()), 64'd0);
    endtask

    // Consumer readiness: mode 0 = never ready, 1 = always ready, 2 = random.
    initial begin
      out_ready = 1'b1;
      forever begin
        @(posedge clk); #1;
        case (ready_mode)
          0:       out_ready = 1'b0;
          1:       out_ready = 1'b1;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
      end
    end

    // Monitor: pops and compares on every transfer, and checks that a stalled
    // output holds.
    logic         prev_stall = 1'b0;
    logic [W+1:0] held = '0;
    always @(negedge clk) begin
      if (reset_n !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check($sformatf("w%0d_stall_hold", W), 64'({out_valid, ovf, cout, s}),
                64'({1'b1, held}));
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w%0d_unexpected_output actual S=%h required no output", W, s);
          end else begin
            check($sformatf("w%0d_result", W), 64'({ovf, cout, s}), 64'(exp_q.pop_front()));
          end
        end
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
        held       = {ovf, cout, s};
      end
    end

    // Main sequence for this configuration.
    initial begin
      logic [W-1:0] ones, msb, maxpos, ra, rb;
      int lat;
      ones = '1;
      msb = '0;
      msb[W-1] = 1'b1;
      maxpos = ones >> 1;
      ready_mode = 1;
      reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #1;
      check($sformatf("w%0d_reset_out", W), 64'({out_valid, ovf, cout, s}), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      check($sformatf("w%0d_reset_in_ready", W), 64'(in_ready), 64'd1);

      // Latency of a single add through an empty pipe. The accepting edge counts as
      // the first stage.
      send(W'(1), W'(2), 1'b1, 1'b0);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("w%0d_latency", W), 64'(lat), 64'(STG));
      drain();

      // Carry-chain, overflow and subtract corners, sent back to back.
      send(ones, '0, 1'b1, 1'b0);
      send(maxpos, W'(1), 1'b0, 1'b0);
      send(W'(5), W'(7), 1'b1, 1'b1);
      send(msb, W'(1), 1'b0, 1'b1);
      send(ones, ones, 1'b1, 1'b0);
      send(W'(3), W'(3), 1'b0, 1'b1);
      send('0, W'(1), 1'b1, 1'b1);
      drain();

      // Random stream with random backpressure and occasional bubbles.
      ready_mode = 2;
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          @(posedge clk); #1;
        end
        ra = W'($urandom);
        rb = W'($urandom);
        if ($urandom_range(0, 7) == 0) ra = ones;
        if ($urandom_range(0, 7) == 0) rb = msb;
        send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain();

      // Reset with operations in flight (stalled at the output for short pipes).
      ready_mode = 0;
      for (int i = 0; i < 3; i++) begin
        a = W'($urandom); b = W'($urandom); cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      check($sformatf("w%0d_midreset_out", W), 64'({out_valid, ovf, cout, s}), 64'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      ready_mode = 1;
      repeat (STG + 4) @(posedge clk);
      #1;
      check($sformatf("w%0d_after_reset_ready", W), 64'(in_ready), 64'd1);
      send(maxpos, maxpos, 1'b0, 1'b0);
      drain();
      done[g] = 1'b1;
    end
  end

  // Wait for every configuration with a cycle budget, then report.
  initial begin
    int n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (!(done[0] && done[1] && done[2])) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d cycles required=completion", n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
